// File: rtl/ddr_sdram_bank_scheduler.sv
// Open-page DDR-SDRAM command scheduler.
// Accepts one burst request at a time. Each bank's open row is tracked, so PRE/ACT are issued
// only on a row miss. Per-bank timing is tracked with saturating "cycles since command" ages.
// Postponed refreshes are counted as debt. Every command bus output is registered.
module ddr_sdram_bank_scheduler #(
    parameter int unsigned ROW_BITS     = 13,
    parameter int unsigned COL_BITS     = 10,
    parameter int unsigned BANK_BITS    = 2,
    parameter int unsigned T_RP         = 2,
    parameter int unsigned T_RCD        = 2,
    parameter int unsigned T_RAS        = 5,
    parameter int unsigned T_WR         = 2,
    parameter int unsigned T_RTW        = 3,
    parameter int unsigned T_RFC        = 10,
    parameter int unsigned T_REFI       = 600,
    parameter int unsigned REF_DEBT_MAX = 7
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 init_done,
    input  logic                                 arw_valid,
    output logic                                 arw_ready,
    input  logic [BANK_BITS+ROW_BITS+COL_BITS:0] arw_addr,
    input  logic [7:0]                           arw_len,
    input  logic                                 arw_write,
    input  logic [1:0]                           arw_id,
    input  logic                                 wvalid,
    input  logic                                 wlast,
    output logic                                 wready,
    output logic                                 bvalid,
    output logic [1:0]                           bid,
    input  logic                                 bready,
    input  logic                                 rd_space,
    output logic                                 rd_issue,
    output logic                                 rd_issue_last,
    output logic [1:0]                           rd_id,
    output logic [2:0]                           cmd_rcw_n,
    output logic [BANK_BITS-1:0]                 cmd_ba,
    output logic [ROW_BITS-1:0]                  cmd_a
);

    localparam int unsigned NUM_BANKS = 2 ** BANK_BITS;
    localparam int unsigned AGE_W     = 6;
    localparam int unsigned REFI_W    = $clog2(T_REFI + 1);
    localparam int unsigned DEBT_W    = $clog2(REF_DEBT_MAX + 1);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] RP_A    = AGE_W'(T_RP);
    localparam logic [AGE_W-1:0] RP_M1   = AGE_W'(T_RP - 1);
    localparam logic [AGE_W-1:0] RCD_A   = AGE_W'(T_RCD);
    localparam logic [AGE_W-1:0] RAS_A   = AGE_W'(T_RAS);
    localparam logic [AGE_W-1:0] WR_A    = AGE_W'(T_WR + 1);
    localparam logic [AGE_W-1:0] RTW_A   = AGE_W'(T_RTW);
    localparam logic [AGE_W-1:0] RFC_A   = AGE_W'(T_RFC);
    localparam logic [AGE_W-1:0] RFC_M1  = AGE_W'(T_RFC - 1);

    localparam logic [REFI_W-1:0] REFI_LOAD = REFI_W'(T_REFI);
    localparam logic [REFI_W-1:0] REFI_ONE  = REFI_W'(1);
    localparam logic [DEBT_W-1:0] DEBT_MAX  = DEBT_W'(REF_DEBT_MAX);

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;

    localparam logic [3:0] S_PREALL   = 4'd0;
    localparam logic [3:0] S_PREALL_W = 4'd1;
    localparam logic [3:0] S_IDLE     = 4'd2;
    localparam logic [3:0] S_PRE      = 4'd3;
    localparam logic [3:0] S_ACT      = 4'd4;
    localparam logic [3:0] S_RW       = 4'd5;
    localparam logic [3:0] S_WRESP    = 4'd6;
    localparam logic [3:0] S_REFPRE   = 4'd7;
    localparam logic [3:0] S_REF      = 4'd8;
    localparam logic [3:0] S_RFC      = 4'd9;

    logic [3:0]           state_q, state_d;
    logic [NUM_BANKS-1:0] open_q, open_d;
    logic [ROW_BITS-1:0]  row_q [NUM_BANKS];
    logic [ROW_BITS-1:0]  row_d [NUM_BANKS];
    logic [AGE_W-1:0]     act_age_q [NUM_BANKS];
    logic [AGE_W-1:0]     act_age_d [NUM_BANKS];
    logic [AGE_W-1:0]     pre_age_q [NUM_BANKS];
    logic [AGE_W-1:0]     pre_age_d [NUM_BANKS];
    logic [AGE_W-1:0]     wr_age_q [NUM_BANKS];
    logic [AGE_W-1:0]     wr_age_d [NUM_BANKS];
    logic [AGE_W-1:0]     rd_age_q, rd_age_d;
    logic [AGE_W-1:0]     ref_age_q, ref_age_d;
    logic [REFI_W-1:0]    refi_q, refi_d;
    logic [DEBT_W-1:0]    debt_q, debt_d;

    // Latched request.
    logic [BANK_BITS-1:0] ba_q, ba_d;
    logic [ROW_BITS-1:0]  rrow_q, rrow_d;
    logic [COL_BITS-1:0]  col_q, col_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           beat_q, beat_d;
    logic                 wr_q, wr_d;
    logic [1:0]           id_q, id_d;

    // Registered outputs.
    logic [2:0]           cmd_q, cmd_d;
    logic [BANK_BITS-1:0] cmd_ba_q, cmd_ba_d;
    logic [ROW_BITS-1:0]  cmd_a_q, cmd_a_d;
    logic                 rd_issue_q, rd_issue_d;
    logic                 rd_last_q, rd_last_d;
    logic [1:0]           rd_id_q, rd_id_d;
    logic [1:0]           bid_q, bid_d;

    logic [BANK_BITS-1:0] req_ba;
    logic [ROW_BITS-1:0]  req_row;
    logic [COL_BITS-1:0]  req_col;
    logic [ROW_BITS-1:0]  col_a;
    logic                 tick, ref_done;
    logic                 pre_ok, rcd_ok, rtw_ok, rfc_ok, all_pre_ok, all_rp_ok;
    logic                 arw_ready_c, wready_c;
    logic                 unused_addr;

    // Byte lane and the low column bit carry no information for 32-bit beats.
    assign unused_addr = ^arw_addr[1:0];
    assign req_ba  = arw_addr[BANK_BITS+ROW_BITS+COL_BITS -: BANK_BITS];
    assign req_row = arw_addr[ROW_BITS+COL_BITS -: ROW_BITS];
    assign req_col = {arw_addr[COL_BITS:2], 1'b0};

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        return (a == AGE_MAX) ? a : a + 1'b1;
    endfunction

    // Column onto the address bus with A10 held low (no auto-precharge).
    always_comb begin
        col_a      = '0;
        col_a[9:0] = col_q[9:0];
        for (int i = 10; i < COL_BITS; i++) begin
            col_a[i+1] = col_q[i];
        end
    end

    // Timing qualifiers for the latched bank and for the all-bank commands.
    always_comb begin
        pre_ok     = (act_age_q[ba_q] >= RAS_A) && (wr_age_q[ba_q] >= WR_A);
        rcd_ok     = act_age_q[ba_q] >= RCD_A;
        rtw_ok     = rd_age_q >= RTW_A;
        rfc_ok     = ref_age_q >= RFC_A;
        all_pre_ok = 1'b1;
        all_rp_ok  = 1'b1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (open_q[b] && ((act_age_q[b] < RAS_A) || (wr_age_q[b] < WR_A))) begin
                all_pre_ok = 1'b0;
            end
            if (pre_age_q[b] < RP_A) begin
                all_rp_ok = 1'b0;
            end
        end
        arw_ready_c = (state_q == S_IDLE) && init_done && (debt_q != DEBT_MAX);
        wready_c    = (state_q == S_RW) && wr_q && rcd_ok && rtw_ok;
    end

    // Scheduler FSM, bank bookkeeping and refresh accounting.
    always_comb begin
        state_d    = state_q;
        open_d     = open_q;
        rd_age_d   = age_inc(rd_age_q);
        ref_age_d  = age_inc(ref_age_q);
        for (int b = 0; b < NUM_BANKS; b++) begin
            row_d[b]     = row_q[b];
            act_age_d[b] = age_inc(act_age_q[b]);
            pre_age_d[b] = age_inc(pre_age_q[b]);
            wr_age_d[b]  = age_inc(wr_age_q[b]);
        end
        ba_d       = ba_q;
        rrow_d     = rrow_q;
        col_d      = col_q;
        len_d      = len_q;
        beat_d     = beat_q;
        wr_d       = wr_q;
        id_d       = id_q;
        cmd_d      = CMD_NOP;
        cmd_ba_d   = '0;
        cmd_a_d    = '0;
        rd_issue_d = 1'b0;
        rd_last_d  = 1'b0;
        rd_id_d    = rd_id_q;
        bid_d      = bid_q;
        ref_done   = 1'b0;

        tick   = init_done && (refi_q <= REFI_ONE);
        refi_d = refi_q;
        if (init_done) begin
            refi_d = tick ? REFI_LOAD : refi_q - 1'b1;
        end

        case (state_q)
            S_PREALL: begin
                if (init_done) begin
                    cmd_d       = CMD_PRE;
                    cmd_a_d[10] = 1'b1;
                    open_d      = '0;
                    for (int b = 0; b < NUM_BANKS; b++) pre_age_d[b] = AGE_W'(1);
                    state_d     = S_PREALL_W;
                end
            end
            S_PREALL_W: begin
                // Leave one cycle early so an ACT decided in IDLE+1 already meets T_RP.
                if (pre_age_q[0] >= RP_M1) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (arw_valid && arw_ready_c) begin
                    ba_d   = req_ba;
                    rrow_d = req_row;
                    col_d  = req_col;
                    len_d  = arw_len;
                    beat_d = '0;
                    wr_d   = arw_write;
                    id_d   = arw_id;
                    if (open_q[req_ba] && (row_q[req_ba] == req_row)) begin
                        state_d = S_RW;
                    end else if (open_q[req_ba]) begin
                        state_d = S_PRE;
                    end else begin
                        state_d = S_ACT;
                    end
                end else if (init_done && (debt_q != '0)) begin
                    state_d = S_REFPRE;
                end
            end
            S_PRE: begin
                if (pre_ok) begin
                    cmd_d           = CMD_PRE;
                    cmd_ba_d        = ba_q;
                    open_d[ba_q]    = 1'b0;
                    pre_age_d[ba_q] = AGE_W'(1);
                    state_d         = S_ACT;
                end
            end
            S_ACT: begin
                if ((pre_age_q[ba_q] >= RP_A) && rfc_ok) begin
                    cmd_d           = CMD_ACT;
                    cmd_ba_d        = ba_q;
                    cmd_a_d         = rrow_q;
                    open_d[ba_q]    = 1'b1;
                    row_d[ba_q]     = rrow_q;
                    act_age_d[ba_q] = AGE_W'(1);
                    state_d         = S_RW;
                end
            end
            S_RW: begin
                if (!wr_q) begin
                    if (rd_space && rcd_ok) begin
                        cmd_d      = CMD_RD;
                        cmd_ba_d   = ba_q;
                        cmd_a_d    = col_a;
                        rd_issue_d = 1'b1;
                        rd_last_d  = (beat_q == len_q);
                        rd_id_d    = id_q;
                        rd_age_d   = AGE_W'(1);
                        col_d      = col_q + COL_BITS'(2);
                        beat_d     = beat_q + 1'b1;
                        if (beat_q == len_q) state_d = S_IDLE;
                    end
                end else if (wvalid && wready_c) begin
                    cmd_d          = CMD_WR;
                    cmd_ba_d       = ba_q;
                    cmd_a_d        = col_a;
                    wr_age_d[ba_q] = AGE_W'(1);
                    col_d          = col_q + COL_BITS'(2);
                    beat_d         = beat_q + 1'b1;
                    if ((beat_q == len_q) || wlast) begin
                        bid_d   = id_q;
                        state_d = S_WRESP;
                    end
                end
            end
            S_WRESP: begin
                if (bready) state_d = S_IDLE;
            end
            S_REFPRE: begin
                if (open_q == '0) begin
                    state_d = S_REF;
                end else if (all_pre_ok) begin
                    cmd_d       = CMD_PRE;
                    cmd_a_d[10] = 1'b1;
                    open_d      = '0;
                    for (int b = 0; b < NUM_BANKS; b++) pre_age_d[b] = AGE_W'(1);
                    state_d     = S_REF;
                end
            end
            S_REF: begin
                if (all_rp_ok) begin
                    cmd_d     = CMD_REF;
                    ref_age_d = AGE_W'(1);
                    ref_done  = 1'b1;
                    state_d   = S_RFC;
                end
            end
            S_RFC: begin
                if (ref_age_q >= RFC_M1) state_d = S_IDLE;
            end
            default: state_d = S_PREALL;
        endcase

        // A credit and a completed refresh in the same cycle cancel out.
        debt_d = debt_q;
        if (tick && !ref_done) begin
            debt_d = (debt_q == DEBT_MAX) ? debt_q : debt_q + 1'b1;
        end else if (!tick && ref_done) begin
            debt_d = debt_q - 1'b1;
        end
    end

    // State and registered outputs; synchronous reset aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_PREALL;
            open_q     <= '0;
            rd_age_q   <= AGE_MAX;
            ref_age_q  <= AGE_MAX;
            refi_q     <= REFI_LOAD;
            debt_q     <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                row_q[b]     <= '0;
                act_age_q[b] <= AGE_MAX;
                pre_age_q[b] <= AGE_MAX;
                wr_age_q[b]  <= AGE_MAX;
            end
            ba_q       <= '0;
            rrow_q     <= '0;
            col_q      <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            wr_q       <= 1'b0;
            id_q       <= '0;
            cmd_q      <= CMD_NOP;
            cmd_ba_q   <= '0;
            cmd_a_q    <= '0;
            rd_issue_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_id_q    <= '0;
            bid_q      <= '0;
        end else begin
            state_q    <= state_d;
            open_q     <= open_d;
            rd_age_q   <= rd_age_d;
            ref_age_q  <= ref_age_d;
            refi_q     <= refi_d;
            debt_q     <= debt_d;
            for (int b = 0; b < NUM_BANKS; b++) begin
                row_q[b]     <= row_d[b];
                act_age_q[b] <= act_age_d[b];
                pre_age_q[b] <= pre_age_d[b];
                wr_age_q[b]  <= wr_age_d[b];
            end
            ba_q       <= ba_d;
            rrow_q     <= rrow_d;
            col_q      <= col_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            wr_q       <= wr_d;
            id_q       <= id_d;
            cmd_q      <= cmd_d;
            cmd_ba_q   <= cmd_ba_d;
            cmd_a_q    <= cmd_a_d;
            rd_issue_q <= rd_issue_d;
            rd_last_q  <= rd_last_d;
            rd_id_q    <= rd_id_d;
            bid_q      <= bid_d;
        end
    end

    assign arw_ready     = arw_ready_c;
    assign wready        = wready_c;
    assign bvalid        = (state_q == S_WRESP);
    assign bid           = bid_q;
    assign rd_issue      = rd_issue_q;
    assign rd_issue_last = rd_last_q;
    assign rd_id         = rd_id_q;
    assign cmd_rcw_n     = cmd_q;
    assign cmd_ba        = cmd_ba_q;
    assign cmd_a         = cmd_a_q;

endmodule

// File: tb/tb_ddr_sdram_bank_scheduler.sv
// Directed bench for ddr_sdram_bank_scheduler: hand-computed command sequences, sampled on negedge.
module tb_ddr_sdram_bank_scheduler;

    localparam int T_REFI = 600;
    localparam int T_RFC  = 10;

    localparam logic [2:0] NOP = 3'b111;
    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] REF = 3'b001;

    logic        clk = 1'b0;
    logic        reset, init_done;
    logic        arw_valid, arw_ready;
    logic [25:0] arw_addr;
    logic [7:0]  arw_len;
    logic        arw_write;
    logic [1:0]  arw_id;
    logic        wvalid, wlast, wready;
    logic        bvalid, bready;
    logic [1:0]  bid;
    logic        rd_space, rd_issue, rd_issue_last;
    logic [1:0]  rd_id;
    logic [2:0]  cmd_rcw_n;
    logic [1:0]  cmd_ba;
    logic [12:0] cmd_a;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    ddr_sdram_bank_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .init_done     (init_done),
        .arw_valid     (arw_valid),
        .arw_ready     (arw_ready),
        .arw_addr      (arw_addr),
        .arw_len       (arw_len),
        .arw_write     (arw_write),
        .arw_id        (arw_id),
        .wvalid        (wvalid),
        .wlast         (wlast),
        .wready        (wready),
        .bvalid        (bvalid),
        .bid           (bid),
        .bready        (bready),
        .rd_space      (rd_space),
        .rd_issue      (rd_issue),
        .rd_issue_last (rd_issue_last),
        .rd_id         (rd_id),
        .cmd_rcw_n     (cmd_rcw_n),
        .cmd_ba        (cmd_ba),
        .cmd_a         (cmd_a)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic req(input logic [1:0] ba, input logic [12:0] row, input logic [9:0] col,
                       input logic [7:0] len, input logic wr, input logic [1:0] id);
        arw_addr  = {ba, row, col, 1'b0};
        arw_len   = len;
        arw_write = wr;
        arw_id    = id;
        arw_valid = 1'b1;
    endtask

    task automatic chk_cmd(input string tag, input logic [2:0] c, input logic [12:0] a);
        check({tag, "_cmd"}, 32'(cmd_rcw_n), 32'(c));
        check({tag, "_a"}, 32'(cmd_a), 32'(a));
    endtask

    initial begin
        int found, pre_all, bad_nop, ready_early, ready_at;
        reset = 1'b1; init_done = 1'b0; arw_valid = 1'b0; arw_addr = '0; arw_len = '0;
        arw_write = 1'b0; arw_id = '0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
        rd_space = 1'b1;
        repeat (3) cyc();
        check("rst_cmd", 32'(cmd_rcw_n), 32'(NOP));
        check("rst_ba", 32'(cmd_ba), 0);
        check("rst_a", 32'(cmd_a), 0);
        check("rst_ready", 32'(arw_ready), 0);
        check("rst_wready", 32'(wready), 0);
        check("rst_bvalid", 32'(bvalid), 0);
        check("rst_rd_issue", 32'({rd_issue, rd_issue_last}), 0);
        check("rst_ids", 32'({bid, rd_id}), 0);

        // Without init_done the scheduler holds NOP.
        reset = 1'b0;
        cyc(); cyc();
        check("noinit_cmd", 32'(cmd_rcw_n), 32'(NOP));
        check("noinit_ready", 32'(arw_ready), 0);

        init_done = 1'b1;
        cyc();
        chk_cmd("preall", PRE, 13'h400);
        check("preall_ready", 32'(arw_ready), 0);
        cyc();
        check("after_preall_cmd", 32'(cmd_rcw_n), 32'(NOP));
        check("after_preall_ready", 32'(arw_ready), 1);

        // Cold read: bank 1 row 5, 4 beats.
        req(2'd1, 13'd5, 10'd0, 8'd3, 1'b0, 2'd2);
        cyc();
        check("cold_accept_nop", 32'(cmd_rcw_n), 32'(NOP));
        arw_valid = 1'b0;
        cyc();
        chk_cmd("cold_act", ACT, 13'd5);
        check("cold_act_ba", 32'(cmd_ba), 1);
        cyc();
        check("cold_trcd_nop", 32'(cmd_rcw_n), 32'(NOP));
        cyc();
        chk_cmd("cold_rd0", RD, 13'd0);
        check("cold_rd0_flags", 32'({rd_issue, rd_issue_last, rd_id}), 32'({1'b1, 1'b0, 2'd2}));
        cyc(); chk_cmd("cold_rd1", RD, 13'd2);
        cyc(); chk_cmd("cold_rd2", RD, 13'd4);
        cyc(); chk_cmd("cold_rd3", RD, 13'd6);
        check("cold_rd3_last", 32'(rd_issue_last), 1);
        cyc();
        check("cold_done_nop", 32'(cmd_rcw_n), 32'(NOP));
        check("cold_done_issue", 32'(rd_issue), 0);

        // Row hit: no ACT, RD two cycles after the handshake cycle.
        req(2'd1, 13'd5, 10'd8, 8'd0, 1'b0, 2'd1);
        cyc();
        check("hit_no_act", 32'(cmd_rcw_n), 32'(NOP));
        arw_valid = 1'b0;
        cyc();
        chk_cmd("hit_rd", RD, 13'd8);
        check("hit_rd_flags", 32'({rd_issue_last, rd_id}), 32'({1'b1, 2'd1}));

        // Row miss: PRE bank (A10=0), T_RP, ACT, T_RCD, RD.
        req(2'd1, 13'd9, 10'd0, 8'd0, 1'b0, 2'd0);
        cyc();
        arw_valid = 1'b0;
        cyc();
        chk_cmd("miss_pre", PRE, 13'd0);
        check("miss_pre_ba", 32'(cmd_ba), 1);
        cyc(); check("miss_trp_nop", 32'(cmd_rcw_n), 32'(NOP));
        cyc(); chk_cmd("miss_act", ACT, 13'd9);
        cyc(); check("miss_trcd_nop", 32'(cmd_rcw_n), 32'(NOP));
        cyc(); chk_cmd("miss_rd", RD, 13'd0);

        // Write len=7 ended by wlast on the third beat; T_RTW holds wready off first.
        req(2'd1, 13'd9, 10'd16, 8'd7, 1'b1, 2'd3);
        wvalid = 1'b1;
        cyc();
        check("wr_rtw_wready", 32'(wready), 0);
        arw_valid = 1'b0;
        cyc();
        check("wr_rtw_nop", 32'(cmd_rcw_n), 32'(NOP));
        check("wr_wready", 32'(wready), 1);
        cyc(); chk_cmd("wr0", WR, 13'd16);
        cyc(); chk_cmd("wr1", WR, 13'd18);
        wlast = 1'b1;
        cyc(); chk_cmd("wr2", WR, 13'd20);
        check("wr_bvalid", 32'({bvalid, bid, wready}), 32'({1'b1, 2'd3, 1'b0}));
        wvalid = 1'b0; wlast = 1'b0;
        cyc();
        check("wr_only3_cmd", 32'(cmd_rcw_n), 32'(NOP));
        check("wr_bvalid_hold1", 32'(bvalid), 1);
        cyc();
        check("wr_bvalid_hold2", 32'(bvalid), 1);
        bready = 1'b1;
        cyc();
        check("wr_bvalid_clear", 32'(bvalid), 0);
        bready = 1'b0;

        // rd_space stall mid-burst.
        req(2'd1, 13'd9, 10'd0, 8'd3, 1'b0, 2'd0);
        cyc();
        arw_valid = 1'b0;
        cyc(); chk_cmd("stall_rd0", RD, 13'd0);
        rd_space = 1'b0;
        cyc();
        check("stall_nop", 32'(cmd_rcw_n), 32'(NOP));
        check("stall_no_issue", 32'(rd_issue), 0);
        rd_space = 1'b1;
        cyc(); chk_cmd("stall_rd1", RD, 13'd2);
        cyc(); cyc();
        check("stall_last", 32'(rd_issue_last), 1);

        // Column wrap within the row.
        req(2'd1, 13'd9, 10'h3FC, 8'd3, 1'b0, 2'd2);
        cyc();
        arw_valid = 1'b0;
        cyc(); chk_cmd("wrap0", RD, 13'h3FC);
        cyc(); chk_cmd("wrap1", RD, 13'h3FE);
        cyc(); chk_cmd("wrap2", RD, 13'h000);
        cyc(); chk_cmd("wrap3", RD, 13'h002);

        // Reset in the middle of a write burst.
        req(2'd1, 13'd9, 10'd0, 8'd3, 1'b1, 2'd1);
        wvalid = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            arw_valid = 1'b0;
            if (cmd_rcw_n == WR) begin
                found = 1;
                break;
            end
        end
        check("rstw_wr_seen", 32'(found), 1);
        reset = 1'b1; wvalid = 1'b0;
        cyc();
        check("rstw_nop", 32'(cmd_rcw_n), 32'(NOP));
        check("rstw_outs", 32'({arw_ready, wready, bvalid, rd_issue}), 0);
        reset = 1'b0;
        cyc();
        chk_cmd("rstw_preall", PRE, 13'h400);
        check("rstw_bvalid", 32'(bvalid), 0);
        cyc();
        check("rstw_ready", 32'(arw_ready), 1);

        // Continuous requests starve refresh until the debt saturates.
        req(2'd1, 13'd9, 10'd0, 8'd0, 1'b0, 2'd0);
        found = 0; pre_all = 0;
        for (int i = 0; i < 8 * T_REFI; i++) begin
            cyc();
            if (cmd_rcw_n == PRE && cmd_a[10]) pre_all = 1;
            if (cmd_rcw_n == REF) begin
                found = 1;
                break;
            end
        end
        check("ref_seen", 32'(found), 1);
        check("ref_preall", 32'(pre_all), 1);
        check("ref_ready_low", 32'(arw_ready), 0);
        bad_nop = 0; ready_early = 0; ready_at = 0;
        for (int k = 1; k <= T_RFC; k++) begin
            cyc();
            if (cmd_rcw_n != NOP) bad_nop++;
            if (k < T_RFC - 1 && arw_ready) ready_early++;
            if (k == T_RFC - 1) ready_at = int'(arw_ready);
        end
        check("rfc_nops", 32'(bad_nop), 0);
        check("rfc_ready_early", 32'(ready_early), 0);
        check("rfc_ready_again", 32'(ready_at), 1);
        cyc();
        chk_cmd("rfc_then_act", ACT, 13'd9);
        arw_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
